// File: rtl/data_sram_responder.sv
`timescale 1ns/1ps
// data_sram_responder
//
// Responder for the CPU data SRAM port. Serves a one-cycle-latency word RAM
// with byte-lane writes, plus a small register window (LED, SWITCH, TIMER,
// CMP, STATUS) selected when addr[31:16] == MMIO_HI.
//
// Ports:
//   clk              single clock, rising edge
//   resetn           asynchronous active-low reset
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables (0 = read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data
//   data_sram_rdata  registered read data (read-before-write)
//   switch           asynchronous board switches
//   led              LED register
//   timer_hit        sticky timer==CMP flag (STATUS[0])

module data_sram_responder #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic        timer_hit
);

    localparam logic [13:0] OFF_LED    = 14'h0000;
    localparam logic [13:0] OFF_SWITCH = 14'h0001;
    localparam logic [13:0] OFF_TIMER  = 14'h0002;
    localparam logic [13:0] OFF_CMP    = 14'h0003;
    localparam logic [13:0] OFF_STATUS = 14'h0004;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic [15:0]       led_q;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic [31:0]       timer_q;
    logic [31:0]       cmp_q;
    logic              hit_q;

    logic              is_mmio;
    logic [13:0]       word_off;
    logic [ADDR_W-1:0] ram_idx;
    logic              wr;
    logic              sel_led;
    logic              sel_timer;
    logic              sel_cmp;
    logic              sel_status;
    logic [31:0]       rd_word;
    logic [31:0]       led_merged;
    logic [31:0]       timer_merged;
    logic [31:0]       cmp_merged;
    logic              status_clr;
    logic              unused_bits;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign is_mmio  = (data_sram_addr[31:16] == MMIO_HI);
    assign word_off = data_sram_addr[15:2];
    assign ram_idx  = data_sram_addr[ADDR_W+1:2];
    assign wr       = data_sram_en && (data_sram_wen != 4'h0);

    assign sel_led    = is_mmio && (word_off == OFF_LED);
    assign sel_timer  = is_mmio && (word_off == OFF_TIMER);
    assign sel_cmp    = is_mmio && (word_off == OFF_CMP);
    assign sel_status = is_mmio && (word_off == OFF_STATUS);

    assign led_merged   = merge_lanes({16'h0000, led_q}, data_sram_wdata, data_sram_wen);
    assign timer_merged = merge_lanes(timer_q, data_sram_wdata, data_sram_wen);
    assign cmp_merged   = merge_lanes(cmp_q, data_sram_wdata, data_sram_wen);
    assign status_clr   = wr && sel_status && data_sram_wen[0] && data_sram_wdata[0];

    // Address byte offset and the LED upper half are architecturally ignored.
    assign unused_bits = ^{data_sram_addr[1:0], led_merged[31:16]};

    // Read mux sees pre-edge state, which gives read-before-write for free.
    always_comb begin
        rd_word = 32'h0000_0000;
        if (is_mmio) begin
            case (word_off)
                OFF_LED:    rd_word = {16'h0000, led_q};
                OFF_SWITCH: rd_word = {16'h0000, sw_sync};
                OFF_TIMER:  rd_word = timer_q;
                OFF_CMP:    rd_word = cmp_q;
                OFF_STATUS: rd_word = {31'h0, hit_q};
                default:    rd_word = 32'h0000_0000;
            endcase
        end else begin
            rd_word = mem[ram_idx];
        end
    end

    // RAM is intentionally not reset so committed data survives resetn.
    always_ff @(posedge clk) begin
        if (wr && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0000_0000;
        end else if (data_sram_en) begin
            data_sram_rdata <= rd_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q <= 16'h0000;
        end else if (wr && sel_led) begin
            led_q <= led_merged[15:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= 16'h0000;
            sw_sync <= 16'h0000;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    // A TIMER write replaces the base of this cycle's increment, so the
    // count after the write edge is the written value plus one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 32'h0000_0000;
        end else if (wr && sel_timer) begin
            timer_q <= timer_merged + 32'd1;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp_q <= 32'hFFFF_FFFF;
        end else if (wr && sel_cmp) begin
            cmp_q <= cmp_merged;
        end
    end

    // Set has priority over a same-cycle W1C clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_q <= 1'b0;
        end else if (timer_q == cmp_q) begin
            hit_q <= 1'b1;
        end else if (status_clr) begin
            hit_q <= 1'b0;
        end
    end

    assign led       = led_q;
    assign timer_hit = hit_q;

endmodule
